// File: rtl/aes_key_schedule.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys,
// one round key per cycle, then serves registered reads of any round key in
// either encrypt or decrypt order.

// Byte-wise AES S-box over a 128-bit vector (SubBytes).
module aes_sub_bytes (
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (b^2 * b^4 * ... * b^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Apply the S-box independently to all sixteen bytes.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < 16; i++) begin
            data_out[i*8 +: 8] = sbox(data_in[i*8 +: 8]);
        end
    end

endmodule

module aes_key_schedule #(
    parameter int REVERSE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         keys_ready,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state_q, state_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic         rk_valid_q, rk_valid_d;

    logic         accept;
    logic [3:0]   prev_idx;
    logic [3:0]   map_idx;
    logic [127:0] prev_key;
    logic [31:0]  rot_word;
    logic [127:0] sub_in;
    logic [127:0] sub_out;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] next_key;

    assign key_ready  = (state_q != EXPAND);
    assign keys_ready = (state_q == READY);
    assign accept     = key_valid && key_ready;
    assign rk_out     = rk_out_q;
    assign rk_valid   = rk_valid_q;

    // The round key being derived from is always the one written last cycle.
    assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
    assign prev_key = rk_q[prev_idx];
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    // Every lane of the shared SubBytes carries the same rotated word, so any
    // lane yields SubWord; the counter simply picks one.
    assign sub_in   = {4{rot_word}};
    assign sub_word = sub_out[{cnt_q[1:0], 5'd0} +: 32];

    aes_sub_bytes u_sub_word (
        .data_in  (sub_in),
        .data_out (sub_out)
    );

    assign t_word   = sub_word ^ {rcon_q, 24'h0};
    assign w0_n     = prev_key[127:96] ^ t_word;
    assign w1_n     = prev_key[95:64]  ^ w0_n;
    assign w2_n     = prev_key[63:32]  ^ w1_n;
    assign w3_n     = prev_key[31:0]   ^ w2_n;
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    assign map_idx = (REVERSE != 0) ? (4'd10 - rd_idx) : rd_idx;

    // Next-state logic: key accept, one expansion step per cycle, and reads.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        rk_d       = rk_q;
        rk_out_d   = rk_out_q;
        rk_valid_d = 1'b0;

        if (keys_ready && rd_en) begin
            rk_valid_d = 1'b1;
            rk_out_d   = (rd_idx > 4'd10) ? 128'h0 : rk_q[map_idx];
        end

        case (state_q)
            EXPAND: begin
                rk_d[cnt_q] = next_key;
                rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    state_d = READY;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                if (accept) begin
                    rk_d[0] = key_in;
                    cnt_d   = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = EXPAND;
                end
            end
        endcase
    end

    // Control and output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rcon_q     <= 8'h01;
            rk_out_q   <= 128'h0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rcon_q     <= rcon_d;
            rk_out_q   <= rk_out_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    // Round-key storage is never cleared; reset only invalidates it via the FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rk_q <= rk_d;
        end
    end

endmodule
